// File: rtl/mdu_if.sv
// Bundle of the EX-stage <-> multiply/divide unit signals.
// The master side is decode/EX. The slave side is the MDU.
interface mdu_if;
  logic [3:0]  mdu_op_i;
  logic        mdu_valid_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic [31:0] mdu_result_o;
  logic        mdu_stall_o;
  logic        mdu_busy_o;

  modport master (
    output mdu_op_i, mdu_valid_i, rs_data_i, rt_data_i,
    input  mdu_result_o, mdu_stall_o, mdu_busy_o
  );

  modport slave (
    input  mdu_op_i, mdu_valid_i, rs_data_i, rt_data_i,
    output mdu_result_o, mdu_stall_o, mdu_busy_o
  );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit holding HI/LO: two-cycle MULT/MULTU, 32-step restoring
// DIV/DIVU with sign fixup, and combinational MUL/MFHI/MFLO result path.
module mdu (
  input  logic clk,
  input  logic rst,
  mdu_if.slave bus
);
  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_MULT  = 4'd4;
  localparam logic [3:0] OP_MULTU = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_MUL1, S_DIV, S_DFIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] quo_q, quo_d;     // dividend/quotient shifter, or multiplicand
  logic [31:0] dvs_q, dvs_d;     // divisor magnitude, or multiplier
  logic [31:0] rem_q, rem_d;
  logic        sgn_a_q, sgn_a_d;
  logic        sgn_b_q, sgn_b_d;
  logic        signed_q, signed_d;
  logic        dz_q, dz_d;

  logic               op_valid;
  logic               accept;
  logic signed [32:0] mul_a;
  logic signed [32:0] mul_b;
  logic signed [65:0] prod;
  logic [32:0]        rem_sh;
  logic [32:0]        trial;
  logic [31:0]        unused_prod_hi;

  assign op_valid = bus.mdu_valid_i && (bus.mdu_op_i >= OP_DIV) && (bus.mdu_op_i <= OP_MTLO);
  assign bus.mdu_stall_o = op_valid && (state_q != S_IDLE);
  assign bus.mdu_busy_o  = (state_q != S_IDLE);
  assign accept = op_valid && (state_q == S_IDLE);

  // 33x33 signed product covers both MULT and zero-extended MULTU.
  assign mul_a = $signed({signed_q & quo_q[31], quo_q});
  assign mul_b = $signed({signed_q & dvs_q[31], dvs_q});
  assign prod  = mul_a * mul_b;
  assign unused_prod_hi = {30'd0, prod[65:64]};

  assign rem_sh = {rem_q, quo_q[31]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_comb begin
    case (bus.mdu_op_i)
      OP_MUL:  bus.mdu_result_o = bus.rs_data_i * bus.rt_data_i;
      OP_MFHI: bus.mdu_result_o = hi_q;
      OP_MFLO: bus.mdu_result_o = lo_q;
      default: bus.mdu_result_o = 32'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    sgn_a_d  = sgn_a_q;
    sgn_b_d  = sgn_b_q;
    signed_d = signed_q;
    dz_d     = dz_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.mdu_op_i)
            OP_DIV, OP_DIVU: begin
              sgn_a_d = (bus.mdu_op_i == OP_DIV) && bus.rs_data_i[31];
              sgn_b_d = (bus.mdu_op_i == OP_DIV) && bus.rt_data_i[31];
              quo_d   = sgn_a_d ? -bus.rs_data_i : bus.rs_data_i;
              dvs_d   = sgn_b_d ? -bus.rt_data_i : bus.rt_data_i;
              dz_d    = (bus.rt_data_i == 32'd0);
              rem_d   = 32'd0;
              cnt_d   = 5'd0;
              state_d = S_DIV;
            end
            OP_MULT, OP_MULTU: begin
              quo_d    = bus.rs_data_i;
              dvs_d    = bus.rt_data_i;
              signed_d = (bus.mdu_op_i == OP_MULT);
              state_d  = S_MUL1;
            end
            OP_MTHI: hi_d = bus.rs_data_i;
            OP_MTLO: lo_d = bus.rs_data_i;
            default: ;
          endcase
        end
      end
      S_MUL1: begin
        hi_d    = prod[63:32];
        lo_d    = prod[31:0];
        state_d = S_IDLE;
      end
      S_DIV: begin
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_DFIX;
      end
      S_DFIX: begin
        // A zero divisor leaves rem = |rs|, so the remainder fixup restores rs.
        hi_d    = sgn_a_q ? -rem_q : rem_q;
        lo_d    = dz_q ? 32'hFFFF_FFFF : ((sgn_a_q ^ sgn_b_q) ? -quo_q : quo_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      rem_q    <= 32'd0;
      sgn_a_q  <= 1'b0;
      sgn_b_q  <= 1'b0;
      signed_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      sgn_a_q  <= sgn_a_d;
      sgn_b_q  <= sgn_b_d;
      signed_q <= signed_d;
      dz_q     <= dz_d;
    end
  end
endmodule

// File: tb/tb_mdu.sv
// Directed bench for the multiply/divide unit. Inputs change 1ns after the rising edge.
// Outputs are sampled on the falling edge.
module tb_mdu;
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_MULT  = 4'd4;
  localparam logic [3:0] OP_MULTU = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  mdu_if bus();
  mdu dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic v, input logic [31:0] a, input logic [31:0] b);
    bus.mdu_op_i    = op;
    bus.mdu_valid_i = v;
    bus.rs_data_i   = a;
    bus.rt_data_i   = b;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(OP_MFHI, 1'b1, 32'd0, 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.mdu_busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.mdu_busy_o); end
    total++; if (bus.mdu_stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.mdu_stall_o); end
    total++; if (bus.mdu_result_o !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", bus.mdu_result_o); end
    next_cycle();
    drive(OP_MFLO, 1'b1, 32'd0, 32'd0);
    @(negedge clk);
    total++; if (bus.mdu_result_o !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", bus.mdu_result_o); end
    next_cycle();
    drive(OP_NONE, 1'b0, 32'hDEAD_BEEF, 32'd5);
    @(negedge clk);
    total++; if (bus.mdu_result_o !== 32'd0) begin bad++; $display("FAIL reset_none got=%h exp=0", bus.mdu_result_o); end
    $display("reset: done");
  endtask

  task automatic test_mult(input logic [3:0] op, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    next_cycle();
    drive(op, 1'b1, 32'hFFFF_FFFD, 32'd7);
    @(negedge clk);
    total++; if (bus.mdu_stall_o !== 1'b0) begin bad++; $display("FAIL mult_accept_stall op=%0d got=%b exp=0", op, bus.mdu_stall_o); end
    next_cycle();
    drive(OP_MFLO, 1'b1, 32'd0, 32'd0);
    @(negedge clk);
    total++; if (bus.mdu_stall_o !== 1'b1) begin bad++; $display("FAIL mult_c1_stall op=%0d got=%b exp=1", op, bus.mdu_stall_o); end
    total++; if (bus.mdu_busy_o !== 1'b1) begin bad++; $display("FAIL mult_c1_busy op=%0d got=%b exp=1", op, bus.mdu_busy_o); end
    next_cycle();
    @(negedge clk);
    total++; if (bus.mdu_stall_o !== 1'b0) begin bad++; $display("FAIL mult_c2_stall op=%0d got=%b exp=0", op, bus.mdu_stall_o); end
    total++; if (bus.mdu_result_o !== exp_lo) begin bad++; $display("FAIL mult_lo op=%0d got=%h exp=%h", op, bus.mdu_result_o, exp_lo); end
    next_cycle();
    drive(OP_MFHI, 1'b1, 32'd0, 32'd0);
    @(negedge clk);
    total++; if (bus.mdu_result_o !== exp_hi) begin bad++; $display("FAIL mult_hi op=%0d got=%h exp=%h", op, bus.mdu_result_o, exp_hi); end
    $display("mult op=%0d: hi exp=%h lo exp=%h", op, exp_hi, exp_lo);
  endtask

  task automatic test_back_to_back();
    next_cycle();
    drive(OP_MULT, 1'b1, 32'd3, 32'd5);
    next_cycle();
    drive(OP_MULTU, 1'b1, 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    total++; if (bus.mdu_stall_o !== 1'b1) begin bad++; $display("FAIL b2b_c1_stall got=%b exp=1", bus.mdu_stall_o); end
    next_cycle();
    @(negedge clk);
    total++; if (bus.mdu_stall_o !== 1'b0) begin bad++; $display("FAIL b2b_c2_stall got=%b exp=0", bus.mdu_stall_o); end
    next_cycle();
    drive(OP_MFLO, 1'b1, 32'd0, 32'd0);
    @(negedge clk);
    total++; if (bus.mdu_busy_o !== 1'b1) begin bad++; $display("FAIL b2b_c3_busy got=%b exp=1", bus.mdu_busy_o); end
    next_cycle();
    @(negedge clk);
    total++; if (bus.mdu_result_o !== 32'd0) begin bad++; $display("FAIL b2b_lo got=%h exp=0", bus.mdu_result_o); end
    next_cycle();
    drive(OP_MFHI, 1'b1, 32'd0, 32'd0);
    @(negedge clk);
    total++; if (bus.mdu_result_o !== 32'd1) begin bad++; $display("FAIL b2b_hi got=%h exp=1", bus.mdu_result_o); end
    $display("back_to_back: MULT then MULTU 0x10000*0x10000");
  endtask

  task automatic test_signed_div();
    int n;
    next_cycle();
    drive(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
    next_cycle();
    drive(OP_MFLO, 1'b1, 32'd0, 32'd0);
    n = 0;
    @(negedge clk);
    while (bus.mdu_stall_o === 1'b1 && n < 100) begin
      n++;
      next_cycle();
      @(negedge clk);
    end
    total++; if (n !== 33) begin bad++; $display("FAIL sdiv_stall_cycles got=%0d exp=33", n); end
    total++; if (bus.mdu_busy_o !== 1'b0) begin bad++; $display("FAIL sdiv_idle_busy got=%b exp=0", bus.mdu_busy_o); end
    total++; if (bus.mdu_result_o !== 32'hFFFF_FFFD) begin bad++; $display("FAIL sdiv_lo got=%h exp=fffffffd", bus.mdu_result_o); end
    next_cycle();
    drive(OP_MFHI, 1'b1, 32'd0, 32'd0);
    @(negedge clk);
    total++; if (bus.mdu_result_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sdiv_hi got=%h exp=ffffffff", bus.mdu_result_o); end
    $display("signed_div: -7/2 stall=%0d", n);
  endtask

  task automatic test_div_edge(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int  n;
    logic stall_seen;
    next_cycle();
    drive(op, 1'b1, a, b);
    next_cycle();
    drive(OP_MFHI, 1'b0, 32'd0, 32'd0);
    n = 0;
    stall_seen = 1'b0;
    @(negedge clk);
    while (bus.mdu_busy_o === 1'b1 && n < 100) begin
      n++;
      if (bus.mdu_stall_o !== 1'b0) stall_seen = 1'b1;
      next_cycle();
      @(negedge clk);
    end
    total++; if (n !== 33) begin bad++; $display("FAIL div_busy_cycles a=%h b=%h got=%0d exp=33", a, b, n); end
    total++; if (stall_seen !== 1'b0) begin bad++; $display("FAIL div_nonmdu_stall a=%h b=%h got=1 exp=0", a, b); end
    next_cycle();
    drive(OP_MFHI, 1'b1, 32'd0, 32'd0);
    @(negedge clk);
    total++; if (bus.mdu_result_o !== exp_hi) begin bad++; $display("FAIL div_hi a=%h b=%h got=%h exp=%h", a, b, bus.mdu_result_o, exp_hi); end
    next_cycle();
    drive(OP_MFLO, 1'b1, 32'd0, 32'd0);
    @(negedge clk);
    total++; if (bus.mdu_result_o !== exp_lo) begin bad++; $display("FAIL div_lo a=%h b=%h got=%h exp=%h", a, b, bus.mdu_result_o, exp_lo); end
    $display("div op=%0d a=%h b=%h: hi exp=%h lo exp=%h", op, a, b, exp_hi, exp_lo);
  endtask

  task automatic test_reset_mid_div();
    next_cycle();
    drive(OP_DIV, 1'b1, 32'd100, 32'd3);
    next_cycle();
    drive(OP_NONE, 1'b0, 32'd0, 32'd0);
    repeat (8) next_cycle();
    @(negedge clk);
    total++; if (bus.mdu_busy_o !== 1'b1) begin bad++; $display("FAIL middiv_busy got=%b exp=1", bus.mdu_busy_o); end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(OP_MFHI, 1'b1, 32'd0, 32'd0);
    @(negedge clk);
    total++; if (bus.mdu_busy_o !== 1'b0) begin bad++; $display("FAIL middiv_rst_busy got=%b exp=0", bus.mdu_busy_o); end
    total++; if (bus.mdu_result_o !== 32'd0) begin bad++; $display("FAIL middiv_rst_hi got=%h exp=0", bus.mdu_result_o); end
    next_cycle();
    drive(OP_MFLO, 1'b1, 32'd0, 32'd0);
    @(negedge clk);
    total++; if (bus.mdu_result_o !== 32'd0) begin bad++; $display("FAIL middiv_rst_lo got=%h exp=0", bus.mdu_result_o); end
    next_cycle();
    drive(OP_MTHI, 1'b1, 32'h55, 32'd0);
    @(negedge clk);
    total++; if (bus.mdu_stall_o !== 1'b0) begin bad++; $display("FAIL mthi_stall got=%b exp=0", bus.mdu_stall_o); end
    next_cycle();
    drive(OP_MFHI, 1'b1, 32'd0, 32'd0);
    @(negedge clk);
    total++; if (bus.mdu_result_o !== 32'h55) begin bad++; $display("FAIL mthi_read got=%h exp=55", bus.mdu_result_o); end
    next_cycle();
    drive(OP_MUL, 1'b1, 32'd6, 32'd7);
    @(negedge clk);
    total++; if (bus.mdu_result_o !== 32'd42) begin bad++; $display("FAIL mul_result got=%0d exp=42", bus.mdu_result_o); end
    next_cycle();
    drive(OP_MFHI, 1'b1, 32'd0, 32'd0);
    @(negedge clk);
    total++; if (bus.mdu_result_o !== 32'h55) begin bad++; $display("FAIL mul_keeps_hi got=%h exp=55", bus.mdu_result_o); end
    next_cycle();
    drive(OP_MFLO, 1'b1, 32'd0, 32'd0);
    @(negedge clk);
    total++; if (bus.mdu_result_o !== 32'd0) begin bad++; $display("FAIL mul_keeps_lo got=%h exp=0", bus.mdu_result_o); end
    $display("reset_mid_div: abort, MTHI 0x55, MUL 6*7");
  endtask

  initial begin
    drive(OP_NONE, 1'b0, 32'd0, 32'd0);
    test_reset();
    test_mult(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFEB);
    test_mult(OP_MULTU, 32'h0000_0006, 32'hFFFF_FFEB);
    test_back_to_back();
    test_signed_div();
    test_div_edge(OP_DIVU, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
    test_div_edge(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    test_div_edge(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the SimMIPS core's EX stage. It executes the `mdu_op` codes produced by instruction decode and owns the architectural HI/LO registers:
- MULT/MULTU take two cycles.
- DIV/DIVU use an iterative radix-2 restoring divider.
- MUL, MFHI and MFLO return results to the EX result mux.

While the unit is busy, any further MDU instruction is stalled.

## Interface
- No parameters.
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `mdu_op_i`  in  4  decode encoding: 0 none, 1 DIV, 2 DIVU, 3 MUL, 4 MULT, 5 MULTU, 6 MFHI, 7 MFLO, 8 MTHI, 9 MTLO. Codes 10–15 are treated as none.
- `mdu_valid_i`  in  1  instruction in EX is live (not bubble/flushed).
- `rs_data_i`  in  32  rs operand (dividend, multiplicand, MTHI/MTLO source).
- `rt_data_i`  in  32  rt operand (divisor, multiplier).
- `mdu_result_o`  out  32  MUL: low 32 bits of rs*rt; MFHI: HI; MFLO: LO; otherwise 0.
- `mdu_stall_o`  out  1  EX must hold the current instruction.
- `mdu_busy_o`  out  1  state != IDLE.

## Operation
- **Op acceptance:** `op` = `mdu_valid_i` and `mdu_op_i` in 1..9. An op is accepted on a rising edge where `op` is set and `mdu_stall_o` = 0.
- **Stall:** `mdu_stall_o` = `op` AND (state != IDLE). It is combinational and never asserted in IDLE. Non-MDU instructions proceed while busy (overlap).
- **FSM states:**
  - IDLE:
    - MULT/MULTU accepted → MUL1.
    - DIV/DIVU accepted → DIV.
    - MTHI/MTLO write HI/LO at the accepting edge.
    - MUL/MFHI/MFLO do not change state.
  - MUL1: product computed from registered operands. MULT is signed 33x33, MULTU zero-extended. {HI,LO} ← product at exit edge → IDLE.
  - DIV: 32 iterations, 5-bit counter 0..31. Each iteration: `rem` = {rem[31:0], quo[31]}, 33-bit trial subtract of the divisor magnitude, quotient bit shifted in. After count 31 → DFIX.
  - DFIX: sign fixup, then HI ← remainder, LO ← quotient → IDLE.
- **Division rules:**
  - On accept, latch |rs|, |rt| and sign flags. Flags are cleared for DIVU.
  - Quotient is negated if sign(rs) ^ sign(rt). Remainder is negated if sign(rs).
  - 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0.
  - Divide by zero raises no exception and keeps the same latency: HI = original rs, LO = 0xFFFFFFFF, for both DIV and DIVU.
- **MUL:** combinational, available in IDLE only. Does not modify HI/LO.
- `mdu_result_o` is meaningful only when `mdu_stall_o` = 0.
- **Reset:**
  - State IDLE, HI = LO = 0, counter = 0.
  - `mdu_stall_o` = `mdu_busy_o` = 0.
  - `mdu_result_o` = 0 unless op 3/6/7 is presented.
  - Reset during MUL1/DIV/DFIX aborts the operation. Partial results are never written.

## Timing
- **MULT/MULTU accepted at edge E0:**
  - Busy during cycle 1 (MUL1).
  - HI/LO valid from cycle 2.
  - An MFHI/MFLO presented in cycle 1 stalls exactly 1 cycle.
- **DIV/DIVU accepted at E0:**
  - DIV state in cycles 1–32, DFIX in cycle 33, IDLE in cycle 34.
  - A dependent MDU op presented in cycle 1 stalls 33 cycles and is accepted at the end of cycle 34.
- **Back-to-back:** a MULT can be accepted in the first IDLE cycle after a previous operation completes. There is no dead cycle.
- **MTHI/MTLO accepted at edge E:** MFHI/MFLO in the next cycle sees the new value. No internal forwarding within the same cycle.
- **No cancel input:** an accepted MULT/DIV always completes unless `rst` is asserted.

## Test plan
- **Reset:** assert `rst` 2 cycles, then MFHI and MFLO → `mdu_result_o` = 0, `mdu_stall_o` = 0, `mdu_busy_o` = 0.
- **MULT then MULTU:**
  - MULT rs=0xFFFFFFFD, rt=7, then MFLO next cycle → stall 1 cycle, then LO = 0xFFFFFFEB; MFHI → 0xFFFFFFFF.
  - Repeat with MULTU → HI = 0x00000006, LO = 0xFFFFFFEB.
- **Signed DIV:** rs=0xFFFFFFF9 (−7), rt=2, MFLO presented in cycle 1 → `mdu_stall_o` high for exactly 33 cycles, then LO = 0xFFFFFFFD; MFHI → 0xFFFFFFFF.
  - Check independent non-MDU cycles (`mdu_valid_i` = 0) during the busy period see no stall.
- **Divide edge cases:**
  - DIVU 0x1234 / 0 → 33-cycle busy, HI = 0x1234, LO = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
  - DIVU 0xFFFFFFFF / 0x10 → LO = 0x0FFFFFFF, HI = 0xF.
- **Reset mid-divide:** start DIV 100/3, assert `rst` in cycle 10 → next cycle `mdu_busy_o` = 0 and HI = LO = 0. Then:
  - MTHI 0x55 followed by MFHI → 0x55.
  - MUL 6*7 → `mdu_result_o` = 42 in the same cycle, with HI/LO unchanged.
